// File: rtl/mask_pkg.sv
// mask_pkg: shared constants and FSM state type for the masking front end.
package mask_pkg;
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;
    typedef enum logic [1:0] {IDLE, GEN, OUT} state_e;
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with seed load; zero seeds fall back to SEED.
module lfsr_galois #(
    parameter int             W    = 32,
    parameter logic [W-1:0]   SEED = 32'hACE1_2468,
    parameter logic [W-1:0]   POLY = 32'h8020_0003
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         bit_out,
    output logic [W-1:0] state
);
    logic [W-1:0] state_q, state_d;
    always_comb begin
        state_d = load ? ((load_val == '0) ? SEED : load_val)
                : step ? ((state_q >> 1) ^ (state_q[0] ? POLY : '0))
                : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= SEED;
        else     state_q <= state_d;
    end
    assign bit_out = state_q[0];
    assign state   = state_q;
endmodule

// File: rtl/mask_share_gen.sv
// mask_share_gen: latches plain operands, collects 2N fresh LFSR bits serially,
// and presents Boolean share pairs on a valid/ready output handshake.
module mask_share_gen
    import mask_pkg::*;
#(
    parameter int                N      = 4,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      a0,
    output logic [N-1:0]      a1,
    output logic [N-1:0]      b0,
    output logic [N-1:0]      b1,
    output logic              c_out
);
    localparam int CW = $clog2(2 * N) + 1;
    state_e            state_q, state_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic              c_q, c_d;
    logic [2*N-1:0]    mask_q, mask_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              lfsr_bit, accept, gen_step;
    logic [LFSR_W-1:0] lfsr_unused;
    assign in_ready = (state_q == IDLE) | ((state_q == OUT) & out_ready);
    assign accept   = in_valid & in_ready;
    // a seed load stalls collection for that cycle
    assign gen_step = (state_q == GEN) & ~seed_load;
    lfsr_galois #(
        .W    (LFSR_W),
        .SEED (SEED),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (gen_step),
        .load     (seed_load),
        .load_val (seed_in),
        .bit_out  (lfsr_bit),
        .state    (lfsr_unused)
    );
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            c_d     = c_in;
            cnt_d   = '0;
            state_d = GEN;
        end else if (state_q == OUT && out_ready) begin
            state_d = IDLE;
        end
        if (gen_step) begin
            mask_d = {lfsr_bit, mask_q[2*N-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(2 * N - 1)) state_d = OUT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end
    assign out_valid = (state_q == OUT);
    assign a0        = a_q ^ mask_q[N-1:0];
    assign a1        = mask_q[N-1:0];
    assign b0        = b_q ^ mask_q[2*N-1:N];
    assign b1        = mask_q[2*N-1:N];
    assign c_out     = c_q;
endmodule

// File: tb/tb_mask_share_gen.sv
// tb_mask_share_gen: table-driven directed vectors, backpressure/seed/reset sequences,
// and random traffic against a sequence-level LFSR model.
module tb_mask_share_gen;
    localparam int          N    = 4;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [N-1:0] a = '0, b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [N-1:0] a0, a1, b0, b1;
    logic        c_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl;

    mask_share_gen #(.N(N), .LFSR_W(32), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c_out(c_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] seed;
        logic [3:0]  a, b;
        logic        c;
        logic [3:0]  ea0, ea1, eb0, eb1;
    } vec_t;
    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // next 2N bits of the pseudo-random sequence, first bit in position 0
    task automatic gen_mask(output logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            m[i] = mdl[0];
            mdl  = lfsr_next(mdl);
        end
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        tick();
        seed_load = 1'b0;
        mdl = (s == 0) ? SEED : s;
    endtask

    task automatic start(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int n = 0;
        in_valid = 1'b1;
        a = ta; b = tb; c_in = tc;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    // accept edge, then count edges up to the first out_valid
    task automatic finish_wait(output int lat);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic expect_shares(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                                 input logic tc, input logic [7:0] m);
        check({tag, "_a0"}, a0, ta ^ m[3:0]);
        check({tag, "_a1"}, a1, m[3:0]);
        check({tag, "_b0"}, b0, tb ^ m[7:4]);
        check({tag, "_b1"}, b1, m[7:4]);
        check({tag, "_c"}, c_out, tc);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] m;
        logic [3:0] sa0, sa1, sb0, sb1;
        logic [3:0] ra, rb;
        logic rc;
        int ones;
        int aborted_seen;
        bit b2b;

        tbl[0] = '{32'h1, 4'h5, 4'h3, 1'b1, 4'hE, 4'hB, 4'hE, 4'hD};
        tbl[1] = '{32'h1, 4'h0, 4'h0, 1'b0, 4'hB, 4'hB, 4'hD, 4'hD};
        tbl[2] = '{32'h1, 4'hF, 4'hF, 1'b1, 4'h4, 4'hB, 4'h2, 4'hD};
        tbl[3] = '{32'h0, 4'h6, 4'h9, 1'b0, 4'hE, 4'h8, 4'hE, 4'h7};

        tick();
        tick();
        rst = 1'b0;
        mdl = SEED;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_shares", {a0, a1, b0, b1}, 16'h0);
        check("rst_c_out", c_out, 0);

        for (int i = 0; i < 4; i++) begin
            load_seed(tbl[i].seed);
            start(tbl[i].a, tbl[i].b, tbl[i].c);
            finish_wait(lat);
            check("tbl_latency", lat, 9);
            check("tbl_a0", a0, tbl[i].ea0);
            check("tbl_a1", a1, tbl[i].ea1);
            check("tbl_b0", b0, tbl[i].eb0);
            check("tbl_b1", b1, tbl[i].eb1);
            check("tbl_c", c_out, tbl[i].c);
            gen_mask(m);
            check("tbl_model", {a1, b1}, {m[3:0], m[7:4]});
            release_out();
        end

        // backpressure: shares hold and in_ready stays low while out_ready=0
        load_seed(32'h1);
        start(4'h5, 4'h3, 1'b1);
        finish_wait(lat);
        gen_mask(m);
        expect_shares("bp", 4'h5, 4'h3, 1'b1, m);
        sa0 = a0; sa1 = a1; sb0 = b0; sb1 = b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_stable", {a0, a1, b0, b1}, {sa0, sa1, sb0, sb1});
            check("bp_in_ready", in_ready, 0);
            check("bp_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 4'hA; b = 4'h6; c_in = 1'b0;
        #1;
        check("bp_in_ready_comb", in_ready, 1);
        finish_wait(lat);
        check("b2b_spacing", lat, 9);
        gen_mask(m);
        expect_shares("b2b", 4'hA, 4'h6, 1'b0, m);
        release_out();

        // seed load (zero -> SEED) on the third GEN cycle stalls collection once
        load_seed(32'h1);
        start(4'h9, 4'h4, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        seed_load = 1'b1;
        seed_in   = 32'h0;
        tick();
        seed_load = 1'b0;
        check("seed_holds_default", dut.u_lfsr.state_q, SEED);
        lat = 4;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("seed_stall_latency", lat, 10);
        for (int i = 0; i < 2; i++) begin
            m[i] = mdl[0];
            mdl  = lfsr_next(mdl);
        end
        mdl = SEED;
        for (int i = 2; i < 8; i++) begin
            m[i] = mdl[0];
            mdl  = lfsr_next(mdl);
        end
        check("seed_stall_mask", {b1, a1}, 8'hE3);
        expect_shares("seed", 4'h9, 4'h4, 1'b1, m);
        release_out();

        load_seed(32'h0);
        check("zero_seed_nonzero", dut.u_lfsr.state_q != 0, 1);

        // reset mid-GEN aborts the transaction and reloads SEED
        load_seed(32'h1);
        start(4'h7, 4'h2, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        seed_load = 1'b1;
        seed_in = 32'h5;
        tick();
        rst = 1'b0;
        seed_load = 1'b0;
        mdl = SEED;
        check("abort_idle", in_ready, 1);
        aborted_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) aborted_seen++;
            tick();
        end
        check("abort_no_valid", aborted_seen, 0);
        start(4'h1, 4'h8, 1'b0);
        finish_wait(lat);
        gen_mask(m);
        check("post_reset_mask", {b1, a1}, 8'h78);
        expect_shares("post_reset", 4'h1, 4'h8, 1'b0, m);
        release_out();

        // random traffic with gaps, backpressure and back-to-back accepts
        ones = 0;
        b2b = 1'b0;
        ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if (!b2b) begin
                repeat ($urandom_range(0, 3)) tick();
                start(ra, rb, rc);
            end
            finish_wait(lat);
            gen_mask(m);
            expect_shares("rnd", ra, rb, rc, m);
            check("rnd_sum", 5'(a0 ^ a1) + 5'(b0 ^ b1) + 5'(c_out), 5'(ra) + 5'(rb) + 5'(rc));
            for (int k = 0; k < N; k++) ones += int'(a1[k]) + int'(b1[k]);
            repeat ($urandom_range(0, 3)) tick();
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            b2b = ($urandom_range(0, 1) == 1);
            out_ready = 1'b1;
            if (b2b) begin
                in_valid = 1'b1;
                a = ra; b = rb; c_in = rc;
            end else begin
                tick();
                out_ready = 1'b0;
            end
        end
        if (b2b) begin
            tick();
            in_valid = 1'b0;
            out_ready = 1'b0;
        end
        check("mask_bias", (ones > 5400) && (ones < 6600), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
